// File: rtl/vga_sync_gen.sv
// 640x480@60 timing generator: pixel-rate divider, h/v counters and registered sync decode.
// Optional frame counter output is built only when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_d,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       p_tick,
`ifdef VGA_FRAME_CNT_EN
    output logic       frame_start,
    output logic [7:0] frame_cnt
`else
    output logic       frame_start
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_L   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_L   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [9:0]       h_cnt_reg, h_cnt_next;
    logic [9:0]       v_cnt_reg, v_cnt_next;
    logic             adv;

    logic [9:0] pixel_x_reg, pixel_y_reg;
    logic       video_on_reg, hsync_reg, vsync_reg, p_tick_reg, frame_start_reg;
    logic       video_on_next, hsync_next, vsync_next, p_tick_next, frame_start_next;

    // With CLK_DIV=1 the divider is a constant zero and adv stays high.
    assign adv = (div_cnt_reg == DIV_LAST);

    always_comb begin
        div_cnt_next = adv ? '0 : div_cnt_reg + 1'b1;
        h_cnt_next   = h_cnt_reg;
        v_cnt_next   = v_cnt_reg;
        if (adv) begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_next = '0;
                v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_next = h_cnt_reg + 10'd1;
            end
        end
    end

    // Decode from the counter state so the registered outputs all describe the same (h,v).
    // A counter value is new exactly when the divider has just wrapped to zero.
    always_comb begin
        video_on_next    = (h_cnt_reg < H_DISP_L) && (v_cnt_reg < V_DISP_L);
        hsync_next       = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
        vsync_next       = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
        p_tick_next      = (div_cnt_reg == '0);
        frame_start_next = p_tick_next && (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
    end

    always_ff @(posedge clk_d) begin
        if (reset) begin
            div_cnt_reg     <= '0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            video_on_reg    <= 1'b0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            p_tick_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            pixel_x_reg     <= h_cnt_reg;
            pixel_y_reg     <= v_cnt_reg;
            video_on_reg    <= video_on_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            p_tick_reg      <= p_tick_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign video_on    = video_on_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign p_tick      = p_tick_reg;
    assign frame_start = frame_start_reg;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_reg;

    // Updates on the same edge that raises frame_start, so the new count appears with it.
    always_ff @(posedge clk_d) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (frame_start_next) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-geometry instance and a tiny-geometry CLK_DIV=1 instance,
// both checked every cycle against an arithmetic model driven by cycles elapsed since reset.
module tb_vga_sync_gen;

    // Small geometry for instance B so whole frames fit in the run.
    localparam int BD = 1, BHD = 8, BHF = 2, BHS = 3, BHB = 2, BVD = 6, BVF = 1, BVS = 2, BVB = 1;
    localparam int B_FRAME = BD * (BHD + BHF + BHS + BHB) * (BVD + BVF + BVS + BVB);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic von_a, hs_a, vs_a, pt_a, fs_a;
    logic von_b, hs_b, vs_b, pt_b, fs_b;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    vga_sync_gen dut_a (
        .clk_d(clk), .reset(reset), .pixel_x(x_a), .pixel_y(y_a), .video_on(von_a),
        .hsync(hs_a), .vsync(vs_a), .p_tick(pt_a),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(fs_a), .frame_cnt(fc_a)
`else
        .frame_start(fs_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(BD), .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) dut_b (
        .clk_d(clk), .reset(reset), .pixel_x(x_b), .pixel_y(y_b), .video_on(von_b),
        .hsync(hs_b), .vsync(vs_b), .p_tick(pt_b),
`ifdef VGA_FRAME_CNT_EN
        .frame_start(fs_b), .frame_cnt(fc_b)
`else
        .frame_start(fs_b)
`endif
    );

    typedef struct {
        int x, y, von, hs, vs, pt, fs, fc;
    } exp_t;

    int compared = 0;
    int mismatched = 0;
    int n_a = -1, n_b = -1;     // clk edges since reset release (-1 while in reset)
    int cyc = 0;
    int last_fs_b = -1;
    int hs_low_cnt = 0, hs_first = -1, hs_last = -1, von_fall_x = -1;

    // n-th clk edge after release shows pixel n/cd in raster order.
    function automatic exp_t model(int n, int cd, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb);
        exp_t e;
        int ht, vt, idx;
        if (n < 0) begin
            e = '{x: 0, y: 0, von: 0, hs: 1, vs: 1, pt: 0, fs: 0, fc: 0};
        end else begin
            ht    = hd + hf + hsw + hb;
            vt    = vd + vf + vsw + vb;
            idx   = n / cd;
            e.x   = idx % ht;
            e.y   = (idx / ht) % vt;
            e.pt  = (n % cd == 0) ? 1 : 0;
            e.von = (e.x < hd && e.y < vd) ? 1 : 0;
            e.hs  = (e.x >= hd + hf && e.x < hd + hf + hsw) ? 0 : 1;
            e.vs  = (e.y >= vd + vf && e.y < vd + vf + vsw) ? 0 : 1;
            e.fs  = (e.pt == 1 && e.x == 0 && e.y == 0) ? 1 : 0;
            e.fc  = (n / (cd * ht * vt) + 1) % 256;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            if (mismatched <= 40)
                $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_all();
        exp_t ea, eb;
        ea = model(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        eb = model(n_b, BD, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB);
        chk("a_pixel_x", 32'(x_a), ea.x);
        chk("a_pixel_y", 32'(y_a), ea.y);
        chk("a_video_on", 32'(von_a), ea.von);
        chk("a_hsync", 32'(hs_a), ea.hs);
        chk("a_vsync", 32'(vs_a), ea.vs);
        chk("a_p_tick", 32'(pt_a), ea.pt);
        chk("a_frame_start", 32'(fs_a), ea.fs);
        chk("b_pixel_x", 32'(x_b), eb.x);
        chk("b_pixel_y", 32'(y_b), eb.y);
        chk("b_video_on", 32'(von_b), eb.von);
        chk("b_hsync", 32'(hs_b), eb.hs);
        chk("b_vsync", 32'(vs_b), eb.vs);
        chk("b_p_tick", 32'(pt_b), eb.pt);
        chk("b_frame_start", 32'(fs_b), eb.fs);
`ifdef VGA_FRAME_CNT_EN
        chk("a_frame_cnt", 32'(fc_a), ea.fc);
        chk("b_frame_cnt", 32'(fc_b), eb.fc);
`endif
        if (n_b >= 0 && fs_b === 1'b1) begin
            if (last_fs_b >= 0) chk("b_frame_period", cyc - last_fs_b, B_FRAME);
            last_fs_b = cyc;
        end
        if (n_a >= 0 && n_a < 3200 && pt_a === 1'b1) begin
            if (hs_a === 1'b0) begin
                hs_low_cnt++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
            if (von_a === 1'b0 && von_fall_x < 0) von_fall_x = int'(x_a);
        end
    endtask

    task automatic step(input logic rst);
        reset = rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            n_a = -1;
            n_b = -1;
            last_fs_b = -1;
        end else begin
            n_a++;
            n_b++;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int len, bound;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(1'b1);
        $display("reset held 3 cycles: hsync=%0b vsync=%0b video_on=%0b", hs_a, vs_a, von_a);

        for (int i = 0; i < 3300; i++) step(1'b0);
        chk("a_hsync_low_pixels", hs_low_cnt, 96);
        chk("a_hsync_first_x", hs_first, 656);
        chk("a_hsync_last_x", hs_last, 751);
        chk("a_video_off_x", von_fall_x, 640);
        $display("line 0 scanned: hsync low %0d pixels (%0d..%0d), video_on off at x=%0d",
                 hs_low_cnt, hs_first, hs_last, von_fall_x);

        // Reset in the middle of the hsync pulse must not leave a glitch.
        bound = 0;
        while (!(x_a == 10'd700 && pt_a === 1'b1) && bound < 4000) begin
            step(1'b0);
            bound++;
        end
        chk("a_reach_x700_timeout", (bound < 4000) ? 1 : 0, 1);
        step(1'b1);
        chk("a_hsync_after_reset", 32'(hs_a), 1);
        chk("a_x_after_reset", 32'(x_a), 0);
        step(1'b0);
        $display("reset at x=700 line 1: restart x=%0d y=%0d frame_start=%0b", x_a, y_a, fs_a);

        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(10, 2000));
            for (int i = 0; i < len; i++) step(1'b0);
            len = int'($urandom_range(1, 3));
            for (int i = 0; i < len; i++) step(1'b1);
            $display("random reset %0d: ran then held reset %0d cycles", k, len);
        end

        for (int i = 0; i < 256 * B_FRAME + 300; i++) step(1'b0);
        $display("free run: instance B passed 256 frame boundaries, last frame_start at cyc %0d",
                 last_fs_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
